fft_stage_ctrl: RTL and testbench
=================================

FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 SHALL have parameter N_STAGES, default 4: number of radix-2 stages issued per transform (16-point FFT).
REQ-002 SHALL have parameter TIMEOUT, default 32: maximum number of WAIT cycles allowed per stage before an error is raised.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port fft_start, input, 1 bit: transform request; sampled only in IDLE.
REQ-006 SHALL have port map_done, input, 1 bit: single-cycle pulse from the coefficient mapper marking end of the current stage.
REQ-007 SHALL have port start, output, 1 bit: single-cycle stage-start pulse driven to the coefficient mapper.
REQ-008 SHALL have port stage, output, 2 bits: index of the stage being processed, valid whenever start is high and throughout WAIT.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port fft_done, output, 1 bit: single-cycle pulse on completion of the final stage.
REQ-011 SHALL have port error, output, 1 bit: sticky timeout flag.
REQ-012 SHALL have port wait_cnt, output, 6 bits: number of cycles spent in WAIT for the current stage.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, ISSUE, WAIT, DONE and ERR; all outputs are registered or decoded from state only.
REQ-014 IDLE: if fft_start=1 at an edge, the FSM SHALL load stage=0 and enter ISSUE; otherwise it stays in IDLE.
REQ-015 ISSUE: start SHALL be high for exactly one cycle, wait_cnt SHALL clear to 0, and the FSM SHALL enter WAIT at the next edge.
REQ-016 WAIT: wait_cnt SHALL increment by 1 on every edge and saturate at 63.
REQ-017 WAIT, map_done=1 with stage < N_STAGES-1: stage SHALL increment by 1 and the FSM SHALL enter ISSUE.
REQ-018 WAIT, map_done=1 with stage = N_STAGES-1: stage SHALL hold and the FSM SHALL enter DONE.
REQ-019 WAIT, map_done=0 with wait_cnt = TIMEOUT-1: the FSM SHALL enter ERR.
REQ-020 If map_done and the timeout condition occur in the same cycle, map_done SHALL take priority.
REQ-021 DONE: fft_done SHALL be high for one cycle, then the FSM SHALL return to IDLE; stage keeps its last value.
REQ-022 ERR: error SHALL be high and busy high; the FSM SHALL remain in ERR, ignoring all inputs, until reset.
REQ-023 Latency: fft_start sampled at edge E SHALL produce start=1, stage=0 in the cycle following E.
REQ-024 Latency: map_done sampled at edge E SHALL produce the next start pulse in the cycle following E.
REQ-025 Stage-to-stage spacing SHALL be a minimum of 2 cycles between start pulses.
REQ-026 The FSM SHALL ignore map_done in IDLE, ISSUE and DONE.
REQ-027 The FSM SHALL ignore fft_start while busy=1; no request is queued.
REQ-028 fft_start held high continuously SHALL launch a new transform in the cycle after each return to IDLE.
REQ-029 Stage arithmetic SHALL be unsigned 2-bit; the increment is never applied at N_STAGES-1, so stage never wraps.

Reset
REQ-030 reset=1 at an edge SHALL force IDLE with stage=0, wait_cnt=0, start=0, busy=0, fft_done=0 and error=0.
REQ-031 reset SHALL take priority over all other inputs in any state, including mid-transform and in ERR.
REQ-032 The first fft_start SHALL be accepted at the first edge after reset deasserts.

Verification
REQ-033 Nominal run: fft_start pulse, with map_done returned 3 cycles after each start -> start pulses with stage 0,1,2,3, each start 4 cycles after the previous one, fft_done one cycle after the 4th map_done, busy low afterwards.
REQ-034 Immediate done: map_done asserted in the first WAIT cycle of every stage -> start pulses exactly 2 cycles apart, wait_cnt never exceeds 1.
REQ-035 Timeout: no map_done after the first start -> error=1 when wait_cnt reaches 31, start never reasserts, error stays high until reset, after which all outputs are 0.
REQ-036 Race: map_done arrives in the same cycle as wait_cnt=31 -> no error, stage advances.
REQ-037 Protocol noise: fft_start pulsed while busy, and map_done pulsed in IDLE and in ISSUE -> no extra start pulse, stage unaffected.
REQ-038 Mid-run reset: reset asserted while stage=2 in WAIT -> IDLE next cycle with stage=0; a following fft_start restarts from stage 0.

Source files
------------

// File: rtl/fft_stage_ctrl.sv
// -----------------------------------------------------------------------------
// fft_stage_ctrl
//
// Sequences the radix-2 stages of one FFT transform. Each stage is launched
// with a single-cycle start pulse to the coefficient mapper. The controller
// then waits for the mapper's map_done pulse. A stage that takes too long
// latches a sticky error, which only reset clears.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   fft_start  in   transform request (only looked at while idle)
//   map_done   in   end-of-stage pulse from the coefficient mapper
//   start      out  one-cycle stage-start pulse to the mapper
//   stage      out  index of the stage being issued / waited on
//   busy       out  high in every state except IDLE
//   fft_done   out  one-cycle pulse after the final stage completes
//   error      out  sticky stage timeout flag
//   wait_cnt   out  cycles spent waiting on the current stage (saturates at 63)
//
// All outputs come straight from flops. The pulse and flag outputs are
// registered from the next-state value, so they line up with the state
// they describe.
// -----------------------------------------------------------------------------
module fft_stage_ctrl #(
    parameter int N_STAGES = 4,
    parameter int TIMEOUT  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fft_start,
    input  logic       map_done,
    output logic       start,
    output logic [1:0] stage,
    output logic       busy,
    output logic       fft_done,
    output logic       error,
    output logic [5:0] wait_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [1:0] LAST_STAGE   = 2'(N_STAGES - 1);
    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT - 1);
    localparam logic [5:0] WAIT_MAX     = 6'd63;

    state_t     state_q, state_d;
    logic [1:0] stage_q, stage_d;
    logic [5:0] wait_cnt_q, wait_cnt_d;
    logic [5:0] wait_cnt_inc;
    logic       start_q, busy_q, fft_done_q, error_q;

    assign wait_cnt_inc = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 6'd1;

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (fft_start) begin
                    state_d    = S_ISSUE;
                    stage_d    = 2'd0;
                    wait_cnt_d = 6'd0;
                end
            end

            S_ISSUE: begin
                state_d    = S_WAIT;
                wait_cnt_d = 6'd0;
            end

            S_WAIT: begin
                wait_cnt_d = wait_cnt_inc;
                // map_done wins over a timeout landing in the same cycle.
                if (map_done) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ISSUE;
                        stage_d    = stage_q + 2'd1;
                        // The count belongs to the stage just finished.
                        // Restart it for the stage about to be issued.
                        wait_cnt_d = 6'd0;
                    end
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d = S_ERR;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            stage_q    <= 2'd0;
            wait_cnt_q <= 6'd0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            fft_done_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            wait_cnt_q <= wait_cnt_d;
            start_q    <= (state_d == S_ISSUE);
            busy_q     <= (state_d != S_IDLE);
            fft_done_q <= (state_d == S_DONE);
            error_q    <= (state_d == S_ERR);
        end
    end

    assign start    = start_q;
    assign stage    = stage_q;
    assign busy     = busy_q;
    assign fft_done = fft_done_q;
    assign error    = error_q;
    assign wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_stage_ctrl
//
// Testbench for fft_stage_ctrl. A table of per-cycle vectors holds the
// inputs for one cycle and the outputs expected after that cycle's edge.
// It covers reset, a nominal run with protocol noise, back-to-back stages,
// and a held fft_start. Hand-written sequences follow for the timeout, the
// map_done/timeout race and a reset part-way through a run.
// -----------------------------------------------------------------------------
module tb_fft_stage_ctrl;

    logic       clk;
    logic       reset;
    logic       fft_start;
    logic       map_done;
    logic       start;
    logic [1:0] stage;
    logic       busy;
    logic       fft_done;
    logic       error;
    logic [5:0] wait_cnt;

    int total;
    int bad;

    fft_stage_ctrl #(
        .N_STAGES(4),
        .TIMEOUT (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .fft_start(fft_start),
        .map_done (map_done),
        .start    (start),
        .stage    (stage),
        .busy     (busy),
        .fft_done (fft_done),
        .error    (error),
        .wait_cnt (wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fs;
        logic       md;
        logic       rs;
        logic       e_start;
        logic [1:0] e_stage;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
        logic [5:0] e_wait;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fs, input logic md, input logic rs,
                                input logic st, input logic [1:0] sg, input logic bz,
                                input logic dn, input logic er, input logic [5:0] wc);
        vec_t v;
        v.fs = fs; v.md = md; v.rs = rs;
        v.e_start = st; v.e_stage = sg; v.e_busy = bz;
        v.e_done = dn; v.e_err = er; v.e_wait = wc;
        return v;
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic fs, input logic md, input logic rs);
        fft_start = fs;
        map_done  = md;
        reset     = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic st, input logic [1:0] sg,
                           input logic bz, input logic dn, input logic er);
        chk({tag, ".start"},    int'(start),    int'(st));
        chk({tag, ".stage"},    int'(stage),    int'(sg));
        chk({tag, ".busy"},     int'(busy),     int'(bz));
        chk({tag, ".fft_done"}, int'(fft_done), int'(dn));
        chk({tag, ".error"},    int'(error),    int'(er));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        fft_start = 1'b0;
        map_done  = 1'b0;
        reset     = 1'b1;

        //                 fs  md  rs   start stage busy done err wait
        vecs.push_back(mk(0, 0, 1,   0, 2'd0, 0, 0, 0, 6'd0)); // reset state
        // nominal run: map_done 3 cycles after each start, with noise
        vecs.push_back(mk(1, 0, 0,   1, 2'd0, 1, 0, 0, 6'd0)); // first edge after reset
        vecs.push_back(mk(0, 0, 0,   0, 2'd0, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 0, 0,   0, 2'd0, 1, 0, 0, 6'd1));
        vecs.push_back(mk(0, 0, 0,   0, 2'd0, 1, 0, 0, 6'd2));
        vecs.push_back(mk(0, 1, 0,   1, 2'd1, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 1, 0,   0, 2'd1, 1, 0, 0, 6'd0)); // map_done in ISSUE ignored
        vecs.push_back(mk(1, 0, 0,   0, 2'd1, 1, 0, 0, 6'd1)); // fft_start while busy ignored
        vecs.push_back(mk(0, 0, 0,   0, 2'd1, 1, 0, 0, 6'd2));
        vecs.push_back(mk(0, 1, 0,   1, 2'd2, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 0, 0,   0, 2'd2, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 0, 0,   0, 2'd2, 1, 0, 0, 6'd1));
        vecs.push_back(mk(0, 0, 0,   0, 2'd2, 1, 0, 0, 6'd2));
        vecs.push_back(mk(0, 1, 0,   1, 2'd3, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 0, 0,   0, 2'd3, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 0, 0,   0, 2'd3, 1, 0, 0, 6'd1));
        vecs.push_back(mk(0, 0, 0,   0, 2'd3, 1, 0, 0, 6'd2));
        vecs.push_back(mk(0, 1, 0,   0, 2'd3, 1, 1, 0, 6'd3)); // DONE
        vecs.push_back(mk(0, 0, 0,   0, 2'd3, 0, 0, 0, 6'd3)); // IDLE, stage kept
        vecs.push_back(mk(0, 1, 0,   0, 2'd3, 0, 0, 0, 6'd3)); // map_done in IDLE ignored
        // immediate done: map_done in first WAIT cycle of every stage
        vecs.push_back(mk(1, 0, 0,   1, 2'd0, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 0, 0,   0, 2'd0, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 1, 0,   1, 2'd1, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 0, 0,   0, 2'd1, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 1, 0,   1, 2'd2, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 0, 0,   0, 2'd2, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 1, 0,   1, 2'd3, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 0, 0,   0, 2'd3, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 1, 0,   0, 2'd3, 1, 1, 0, 6'd1));
        // fft_start held high: relaunch one cycle after returning to IDLE
        vecs.push_back(mk(1, 0, 0,   0, 2'd3, 0, 0, 0, 6'd1));
        vecs.push_back(mk(1, 0, 0,   1, 2'd0, 1, 0, 0, 6'd0));
        vecs.push_back(mk(1, 0, 0,   0, 2'd0, 1, 0, 0, 6'd0));
        vecs.push_back(mk(0, 0, 1,   0, 2'd0, 0, 0, 0, 6'd0)); // reset mid-transform

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("row%0d", i);
            step(vecs[i].fs, vecs[i].md, vecs[i].rs);
            chk_all(tag, vecs[i].e_start, vecs[i].e_stage, vecs[i].e_busy,
                    vecs[i].e_done, vecs[i].e_err);
            chk({tag, ".wait_cnt"}, int'(wait_cnt), int'(vecs[i].e_wait));
            $display("vec %0d fs=%0b md=%0b rs=%0b -> start=%0b stage=%0d busy=%0b done=%0b err=%0b wait=%0d",
                     i, vecs[i].fs, vecs[i].md, vecs[i].rs, start, stage, busy, fft_done, error, wait_cnt);
        end

        // ---- timeout: no map_done after the first start ----
        step(1, 0, 0);
        chk("to.issue.start", int'(start), 1);
        for (int k = 0; k < 32; k++) begin
            step(0, 0, 0);
            chk($sformatf("to.wait%0d", k), int'(wait_cnt), k);
            chk($sformatf("to.noerr%0d", k), int'(error), 0);
            chk($sformatf("to.nostart%0d", k), int'(start), 0);
        end
        step(0, 0, 0);
        chk_all("to.err", 0, 2'd0, 1, 0, 1);
        for (int k = 0; k < 6; k++) begin
            step(logic'(k % 2), logic'(1 - (k % 2)), 0);
            chk_all($sformatf("to.sticky%0d", k), 0, 2'd0, 1, 0, 1);
        end
        $display("timeout sequence: error=%0b busy=%0b", error, busy);
        step(0, 0, 1);
        chk_all("to.reset", 0, 2'd0, 0, 0, 0);
        chk("to.reset.wait_cnt", int'(wait_cnt), 0);

        // ---- race: map_done in the same cycle as wait_cnt=31 ----
        step(1, 0, 0);
        for (int k = 0; k < 32; k++) step(0, 0, 0);
        chk("race.wait31", int'(wait_cnt), 31);
        step(0, 1, 0);
        chk_all("race.adv", 1, 2'd1, 1, 0, 0);
        step(0, 0, 0);
        chk_all("race.after", 0, 2'd1, 1, 0, 0);
        $display("race sequence: stage=%0d error=%0b", stage, error);
        step(0, 0, 1);

        // ---- reset while stage=2 in WAIT ----
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        chk_all("mid.wait2", 0, 2'd2, 1, 0, 0);
        step(0, 0, 1);
        chk_all("mid.reset", 0, 2'd0, 0, 0, 0);
        step(1, 0, 0);
        chk_all("mid.restart", 1, 2'd0, 1, 0, 0);
        $display("mid-run reset: restart stage=%0d start=%0b", stage, start);
        step(0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
